instr_issue_seq: RTL and testbench

//  Program-driven instruction source for mipscpu. It drives the CPU's instrword/newinstr input port.
//  A small internal program buffer is loaded over a write port. On start, the block issues N words
//  in order. Each word is held stable, a single-cycle newinstr pulse follows, then GAP cycles are

---
 rtl/instr_issue_seq.sv | 164 ++++++++++++++++
 tb/tb_instr_issue_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_seq.sv
// Program-driven instruction source for a multi-cycle CPU: stores a short program and
// issues it word by word, word set up one cycle ahead of a single-cycle strobe, then GAP idle cycles.
module instr_issue_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   num_instr,
    input  logic          abort,
    output logic [31:0]   instrword,
    output logic          newinstr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc
);

    localparam int          CW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_instr;
    logic [31:0]   w_instr_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW:0]   r_num;
    logic [AW:0]   w_num_nxt;
    logic [AW:0]   w_last_idx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_newinstr;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_busy_now;
    logic          w_mem_we;
    logic          w_load;

    assign w_busy_now = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_WAIT);
    assign w_last_idx = r_num - (AW+1)'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_mem_we    = 1'b0;
        w_load      = 1'b0;
        w_instr_nxt = r_instr;

        // Program writes only land while idle; a write racing a running program is flagged.
        if (prog_we) begin
            if (r_state == S_IDLE) begin
                w_mem_we = 1'b1;
            end else if (w_busy_now) begin
                w_err_nxt = 1'b1;
            end
        end

        if (w_busy_now && abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_instr == '0) begin
                            w_state_nxt = S_DONE;
                        end else if (num_instr > DEPTH_L) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_SETUP;
                            w_pc_nxt    = '0;
                            w_num_nxt   = num_instr;
                            w_load      = 1'b1;
                        end
                    end
                end
                S_SETUP: w_state_nxt = S_PULSE;
                S_PULSE: begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(GAP - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if ({1'b0, r_pc} == w_last_idx) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_SETUP;
                            w_pc_nxt    = r_pc + AW'(1);
                            w_load      = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // The word is fetched on entry to SETUP so it is stable a full cycle before the strobe.
        if (w_load) begin
            w_instr_nxt = r_mem[w_pc_nxt];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_pc       <= '0;
            r_num      <= '0;
            r_cnt      <= '0;
            r_newinstr <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_instr    <= w_instr_nxt;
            r_pc       <= w_pc_nxt;
            r_num      <= w_num_nxt;
            r_cnt      <= w_cnt_nxt;
            r_newinstr <= (w_state_nxt == S_PULSE);
            r_busy     <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                          (w_state_nxt == S_WAIT);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= w_err_nxt;
        end
    end

    // Program buffer survives reset so a boot image can be reissued after a CPU reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign instrword = r_instr;
    assign newinstr  = r_newinstr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign pc        = r_pc;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Bench for instr_issue_seq: directed scenarios plus random traffic, all outputs
// checked every cycle against a schedule-based model of the issue timing.
module tb_instr_issue_seq;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int GAP   = 4;
    localparam int P     = GAP + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   num_instr = '0;
    logic          abort = 1'b0;
    logic [31:0]   instrword;
    logic          newinstr;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] pc;

    instr_issue_seq #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .num_instr(num_instr), .abort(abort),
        .instrword(instrword), .newinstr(newinstr), .busy(busy), .done(done),
        .err(err), .pc(pc)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a run is described by its start cycle and length; outputs follow from arithmetic on
    // the cycle offset rel (rel=1 is the first cycle after the start edge).
    logic [31:0]   mem_m [DEPTH];
    logic [31:0]   m_instr = '0;
    logic [AW-1:0] m_pc = '0;
    logic          m_new = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic          run = 1'b0, in_done = 1'b0;
    int            run_n = 0, rel = 0;

    int          pulse_cyc[$];
    logic [31:0] pulse_word[$];
    int          done_cyc[$];
    int          err_cyc[$];
    int          busy_cnt = 0;
    logic        prev_new = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic cur_busy, cur_done;
        int k, ph;
        cyc++;
        m_new = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
        if (!reset) begin
            m_instr = '0; m_pc = '0; run = 1'b0; in_done = 1'b0;
            return;
        end
        cur_busy = run;
        cur_done = in_done;
        in_done  = 1'b0;
        if (prog_we) begin
            if (cur_busy) m_err = 1'b1;
            else if (!cur_done) mem_m[prog_addr] = prog_data;
        end
        if (cur_busy) begin
            if (abort) begin
                run = 1'b0;
            end else begin
                rel++;
                if (rel == run_n * P + 1) begin
                    run = 1'b0; in_done = 1'b1; m_done = 1'b1;
                end else begin
                    k = (rel - 1) / P;
                    ph = (rel - 1) % P;
                    m_instr = mem_m[k];
                    m_pc = AW'(k);
                    m_new = (ph == 1);
                    m_busy = 1'b1;
                end
            end
        end else if (!cur_done && start) begin
            if (num_instr == 0) begin
                in_done = 1'b1; m_done = 1'b1;
            end else if (int'(num_instr) > DEPTH) begin
                m_err = 1'b1;
            end else begin
                run = 1'b1; run_n = int'(num_instr); rel = 1;
                m_instr = mem_m[0]; m_pc = '0; m_busy = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Per-cycle comparison and event logging.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                chk("instrword", instrword, m_instr);
                chk("newinstr", 32'(newinstr), 32'(m_new));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("done", 32'(done), 32'(m_done));
                chk("err", 32'(err), 32'(m_err));
                chk("pc", 32'(pc), 32'(m_pc));
                if (newinstr && prev_new) chk("newinstr_width", 32'(2), 32'(1));
                prev_new = newinstr;
                if (newinstr) begin
                    pulse_cyc.push_back(cyc);
                    pulse_word.push_back(instrword);
                end
                if (done) done_cyc.push_back(cyc);
                if (err) err_cyc.push_back(cyc);
                if (busy) busy_cnt++;
            end else begin
                prev_new = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_logs();
        pulse_cyc.delete(); pulse_word.delete(); done_cyc.delete(); err_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
        @(negedge clock);
        prog_we = 1'b0;
    endtask

    task automatic do_start(input int n, output int t0);
        start = 1'b1; num_instr = (AW+1)'(n); t0 = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        int t0, t1, tw, r;
        // Reset state
        tick(3);
        chk("rst_instrword", instrword, 32'h0);
        chk("rst_newinstr", 32'(newinstr), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_pc", 32'(pc), 32'(0));
        reset = 1'b1;
        tick(5);
        chk("idle_pulses", 32'(pulse_cyc.size()), 32'(0));
        chk("idle_busy", 32'(busy_cnt), 32'(0));

        // Three-word program
        wr(0, 32'h8C010000); wr(1, 32'h8C020001); wr(2, 32'h8C030002);
        tick(1);
        clear_logs();
        do_start(3, t0);
        chk("t2_word_setup", instrword, 32'h8C010000);
        chk("t2_newinstr_setup", 32'(newinstr), 32'(0));
        tick(24);
        chk("t2_npulses", 32'(pulse_cyc.size()), 32'(3));
        if (pulse_cyc.size() == 3) begin
            chk("t2_p0_cyc", 32'(pulse_cyc[0]), 32'(t0 + 2));
            chk("t2_p1_cyc", 32'(pulse_cyc[1]), 32'(t0 + 8));
            chk("t2_p2_cyc", 32'(pulse_cyc[2]), 32'(t0 + 14));
            chk("t2_p0_word", pulse_word[0], 32'h8C010000);
            chk("t2_p1_word", pulse_word[1], 32'h8C020001);
            chk("t2_p2_word", pulse_word[2], 32'h8C030002);
        end
        chk("t2_ndone", 32'(done_cyc.size()), 32'(1));
        if (done_cyc.size() == 1) chk("t2_done_cyc", 32'(done_cyc[0]), 32'(t0 + 19));
        chk("t2_busy_cycles", 32'(busy_cnt), 32'(18));
        chk("t2_pc_end", 32'(pc), 32'(2));

        // N=0 and N=DEPTH+1
        clear_logs();
        do_start(0, t0);
        tick(4);
        chk("t3_n0_done", 32'(done_cyc.size() == 1 ? done_cyc[0] : -1), 32'(t0 + 1));
        chk("t3_n0_busy", 32'(busy_cnt), 32'(0));
        chk("t3_n0_pulses", 32'(pulse_cyc.size()), 32'(0));
        clear_logs();
        do_start(DEPTH + 1, t0);
        tick(4);
        chk("t3_big_err", 32'(err_cyc.size() == 1 ? err_cyc[0] : -1), 32'(t0 + 1));
        chk("t3_big_busy", 32'(busy_cnt), 32'(0));
        chk("t3_big_done", 32'(done_cyc.size()), 32'(0));

        // Abort in the WAIT of word 1, then restart
        clear_logs();
        do_start(3, t0);
        tick(9);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("t4_busy", 32'(busy), 32'(0));
        chk("t4_pc", 32'(pc), 32'(1));
        chk("t4_word_held", instrword, 32'h8C020001);
        tick(20);
        chk("t4_npulses", 32'(pulse_cyc.size()), 32'(2));
        chk("t4_ndone", 32'(done_cyc.size()), 32'(0));
        clear_logs();
        do_start(1, t1);
        tick(10);
        chk("t4_re_word", pulse_word.size() == 1 ? pulse_word[0] : 32'hFFFFFFFF, 32'h8C010000);
        chk("t4_re_cyc", 32'(pulse_cyc.size() == 1 ? pulse_cyc[0] : -1), 32'(t1 + 2));
        chk("t4_re_done", 32'(done_cyc.size() == 1 ? done_cyc[0] : -1), 32'(t1 + 7));

        // Write while busy is dropped
        clear_logs();
        do_start(3, t0);
        tick(2);
        prog_we = 1'b1; prog_addr = '0; prog_data = 32'hDEADBEEF; tw = cyc;
        @(negedge clock);
        prog_we = 1'b0;
        tick(25);
        chk("t5_err", 32'(err_cyc.size() == 1 ? err_cyc[0] : -1), 32'(tw + 1));
        clear_logs();
        do_start(1, t1);
        tick(10);
        chk("t5_word", pulse_word.size() == 1 ? pulse_word[0] : 32'hFFFFFFFF, 32'h8C010000);

        // Asynchronous reset in PULSE
        clear_logs();
        do_start(1, t0);
        @(negedge clock);
        chk("t6_pulse_high", 32'(newinstr), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("t6_async_newinstr", 32'(newinstr), 32'(0));
        chk("t6_async_busy", 32'(busy), 32'(0));
        chk("t6_async_pc", 32'(pc), 32'(0));
        chk("t6_async_word", instrword, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        tick(2);
        clear_logs();
        do_start(1, t1);
        tick(10);
        chk("t6_word", pulse_word.size() == 1 ? pulse_word[0] : 32'hFFFFFFFF, 32'h8C010000);
        chk("t6_cyc", 32'(pulse_cyc.size() == 1 ? pulse_cyc[0] : -1), 32'(t1 + 2));

        // Random traffic against the model
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
        for (int i = 0; i < 1500; i++) begin
            start = 1'b0; prog_we = 1'b0; abort = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                start = 1'b1;
                num_instr = (AW+1)'($urandom_range(0, DEPTH + 3));
            end else if (r < 18) begin
                prog_we = 1'b1;
                prog_addr = AW'($urandom_range(0, DEPTH - 1));
                prog_data = $urandom;
            end else if (r < 20) begin
                abort = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0; prog_we = 1'b0; abort = 1'b0;
        tick(DEPTH * P + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
